// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - 64-bit timer with prescaler, compare flag and debug halt.
module timer_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [11:0] addr,
    input  logic [31:0] wr_data,
    input  logic        halt_req,
    output logic [31:0] rd_data,
    output logic        cmp,
    output logic        int_en,
    output logic        cnt_en,
    output logic        halt_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [11:0] A_TCR   = 12'h000;
    localparam logic [11:0] A_TDR0  = 12'h004;
    localparam logic [11:0] A_TDR1  = 12'h008;
    localparam logic [11:0] A_TCMR0 = 12'h00C;
    localparam logic [11:0] A_TCMR1 = 12'h010;
    localparam logic [11:0] A_TIER  = 12'h014;
    localparam logic [11:0] A_THCSR = 12'h01C;

    state_t      state_q, state_d;
    logic        timer_en_q;
    logic        div_en_q;
    logic [3:0]  div_val_q;
    logic [63:0] cnt_q, cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [63:0] cmp_val_q;
    logic        int_en_q;
    logic        halt_en_q;

    logic        wr_tcr, wr_tdr0, wr_tdr1, wr_tcmr0, wr_tcmr1, wr_tier, wr_thcsr;
    logic        tcr_ok;
    logic        clear;
    logic        run;
    logic        tick;
    logic [7:0]  div_lim;

    assign wr_tcr   = wr_en && (addr == A_TCR);
    assign wr_tdr0  = wr_en && (addr == A_TDR0);
    assign wr_tdr1  = wr_en && (addr == A_TDR1);
    assign wr_tcmr0 = wr_en && (addr == A_TCMR0);
    assign wr_tcmr1 = wr_en && (addr == A_TCMR1);
    assign wr_tier  = wr_en && (addr == A_TIER);
    assign wr_thcsr = wr_en && (addr == A_THCSR);
    assign tcr_ok   = (wr_data[11:8] <= 4'd8);

    // div_val is capped at 8, so the terminal count always fits in 8 bits.
    assign div_lim = 8'((9'd1 << div_val_q) - 9'd1);
    assign run     = (state_q == ST_RUN) && timer_en_q;
    assign tick    = run && (!div_en_q || (div_cnt_q == div_lim));

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (timer_en_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!timer_en_q) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else if (halt_req && halt_en_q) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!timer_en_q) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else if (!(halt_req && halt_en_q)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Software loads of either counter half pre-empt that cycle's increment.
    always_comb begin
        cnt_d     = cnt_q;
        div_cnt_d = div_cnt_q;
        if (clear) begin
            cnt_d     = 64'd0;
            div_cnt_d = 8'd0;
        end else begin
            if (run && div_en_q) div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
            if (wr_tdr0)      cnt_d = {cnt_q[63:32], wr_data};
            else if (wr_tdr1) cnt_d = {wr_data, cnt_q[31:0]};
            else if (tick)    cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_en_q <= 1'b0;
            div_en_q   <= 1'b0;
            div_val_q  <= 4'd0;
            cnt_q      <= 64'd0;
            div_cnt_q  <= 8'd0;
            cmp_val_q  <= {64{1'b1}};
            int_en_q   <= 1'b0;
            halt_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_cnt_q <= div_cnt_d;
            if (wr_tcr && tcr_ok) begin
                timer_en_q <= wr_data[0];
                if (!timer_en_q) begin
                    div_en_q  <= wr_data[1];
                    div_val_q <= wr_data[11:8];
                end
            end
            if (wr_tcmr0) cmp_val_q[31:0]  <= wr_data;
            if (wr_tcmr1) cmp_val_q[63:32] <= wr_data;
            if (wr_tier)  int_en_q  <= wr_data[0];
            if (wr_thcsr) halt_en_q <= wr_data[0];
        end
    end

    assign cmp      = (cnt_q == cmp_val_q);
    assign int_en   = int_en_q;
    assign cnt_en   = tick && !(wr_tdr0 || wr_tdr1);
    assign halt_ack = (state_q == ST_HALT);

    always_comb begin
        rd_data = 32'd0;
        if (rd_en) begin
            case (addr)
                A_TCR:   rd_data = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
                A_TDR0:  rd_data = cnt_q[31:0];
                A_TDR1:  rd_data = cnt_q[63:32];
                A_TCMR0: rd_data = cmp_val_q[31:0];
                A_TCMR1: rd_data = cmp_val_q[63:32];
                A_TIER:  rd_data = {31'd0, int_en_q};
                A_THCSR: rd_data = {30'd0, halt_ack, halt_en_q};
                default: rd_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - randomized and directed checks of timer_ctrl against a reference model.
module tb_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [11:0] addr;
    logic [31:0] wr_data;
    logic        halt_req;
    logic [31:0] rd_data;
    logic        cmp;
    logic        int_en;
    logic        cnt_en;
    logic        halt_ack;

    timer_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .halt_req (halt_req),
        .rd_data  (rd_data),
        .cmp      (cmp),
        .int_en   (int_en),
        .cnt_en   (cnt_en),
        .halt_ack (halt_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: mode 0 = idle, 1 = counting, 2 = halted.
    bit          m_valid = 1'b0;
    int          m_mode;
    bit          m_ten, m_den;
    int          m_dv;
    logic [63:0] m_cnt, m_cmpv;
    int          m_phase;
    bit          m_tier, m_hen;

    bit          rsv = 1'b1;
    bit          hlv = 1'b0;
    logic [31:0] last_rd;
    bit          last_cmp, last_cnt_en, last_halt_ack, last_int_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit model_tick();
        int period;
        period = m_den ? (1 << m_dv) : 1;
        return (m_mode == 1) && m_ten && (m_phase == period - 1);
    endfunction

    function automatic logic [31:0] model_rd(input bit r, input logic [11:0] a);
        if (!r) return 32'd0;
        case (a)
            12'h000: return {20'd0, 4'(m_dv), 6'd0, m_den, m_ten};
            12'h004: return m_cnt[31:0];
            12'h008: return m_cnt[63:32];
            12'h00C: return m_cmpv[31:0];
            12'h010: return m_cmpv[63:32];
            12'h014: return {31'd0, m_tier};
            12'h01C: return {30'd0, (m_mode == 2), m_hen};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit w, input logic [11:0] a, input logic [31:0] d);
        bit tk;
        int period;
        bit old_ten;
        if (rsv) begin
            m_valid = 1'b1;
            m_mode = 0; m_ten = 0; m_den = 0; m_dv = 0;
            m_cnt = 64'd0; m_phase = 0; m_cmpv = {64{1'b1}};
            m_tier = 0; m_hen = 0;
            return;
        end
        tk      = model_tick();
        period  = m_den ? (1 << m_dv) : 1;
        old_ten = m_ten;
        if (m_mode != 0 && !m_ten) begin
            m_mode = 0; m_cnt = 64'd0; m_phase = 0;
        end else begin
            if (m_mode == 1 && m_ten && m_den) m_phase = (m_phase + 1) % period;
            if (w && a == 12'h004)      m_cnt[31:0]  = d;
            else if (w && a == 12'h008) m_cnt[63:32] = d;
            else if (tk)                m_cnt = m_cnt + 64'd1;
            if (m_mode == 0) m_mode = m_ten ? 1 : 0;
            else             m_mode = (hlv && m_hen) ? 2 : 1;
        end
        if (w) begin
            case (a)
                12'h000: if (int'(d[11:8]) <= 8) begin
                    m_ten = d[0];
                    if (!old_ten) begin m_den = d[1]; m_dv = int'(d[11:8]); end
                end
                12'h00C: m_cmpv[31:0]  = d;
                12'h010: m_cmpv[63:32] = d;
                12'h014: m_tier = d[0];
                12'h01C: m_hen  = d[0];
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit w, input bit r, input logic [11:0] a, input logic [31:0] d);
        bit e_tdrw;
        wr_en = w; rd_en = r; addr = a; wr_data = d; halt_req = hlv; rst = rsv;
        #1;
        if (m_valid) begin
            e_tdrw = w && (a == 12'h004 || a == 12'h008);
            check("rd_data",  {32'd0, rd_data},  {32'd0, model_rd(r, a)});
            check("cmp",      {63'd0, cmp},      {63'd0, (m_cnt == m_cmpv)});
            check("cnt_en",   {63'd0, cnt_en},   {63'd0, (model_tick() && !e_tdrw)});
            check("halt_ack", {63'd0, halt_ack}, {63'd0, (m_mode == 2)});
            check("int_en",   {63'd0, int_en},   {63'd0, m_tier});
        end
        last_rd = rd_data; last_cmp = cmp; last_cnt_en = cnt_en;
        last_halt_ack = halt_ack; last_int_en = int_en;
        @(posedge clk);
        model_step(w, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d); cyc(1'b1, 1'b0, a, d); endtask
    task automatic rd(input logic [11:0] a); cyc(1'b0, 1'b1, a, 32'd0); endtask
    task automatic idle(); cyc(1'b0, 1'b0, 12'h000, 32'd0); endtask
    task automatic do_reset(); rsv = 1'b1; hlv = 1'b0; idle(); rsv = 1'b0; endtask

    logic [11:0] addr_tab [8] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                  12'h010, 12'h014, 12'h018, 12'h01C};

    initial begin
        wr_en = 0; rd_en = 0; addr = 0; wr_data = 0; halt_req = 0; rst = 1;
        @(negedge clk);
        do_reset();

        rd(12'h000); check("rst_tcr",   {32'd0, last_rd}, 64'h0);
        rd(12'h00C); check("rst_tcmr0", {32'd0, last_rd}, 64'hFFFF_FFFF);
        rd(12'h010); check("rst_tcmr1", {32'd0, last_rd}, 64'hFFFF_FFFF);
        rd(12'h004); check("rst_tdr0",  {32'd0, last_rd}, 64'h0);
        check("rst_cmp", {63'd0, last_cmp}, 64'h0);

        // Free-running count
        do_reset();
        wr(12'h000, 32'h1); idle();
        for (int i = 0; i < 10; i++) begin
            idle(); check("run_cnt_en", {63'd0, last_cnt_en}, 64'h1);
        end
        rd(12'h004); check("run_tdr0", {32'd0, last_rd}, 64'd10);
        rd(12'h008); check("run_tdr1", {32'd0, last_rd}, 64'd0);

        // Prescaler div_val = 2
        do_reset();
        wr(12'h000, 32'h0000_0203); idle();
        repeat (12) idle();
        rd(12'h004); check("div_tdr0", {32'd0, last_rd}, 64'd3);

        // 64-bit wrap
        do_reset();
        wr(12'h004, 32'hFFFF_FFFF); wr(12'h008, 32'hFFFF_FFFF); wr(12'h000, 32'h1);
        idle(); check("wrap_cmp_allones", {63'd0, last_cmp}, 64'h1);
        idle();
        rd(12'h004); check("wrap_tdr0", {32'd0, last_rd}, 64'd0);
        rd(12'h008); check("wrap_tdr1", {32'd0, last_rd}, 64'd0);

        // Compare flag
        do_reset();
        wr(12'h00C, 32'd5); wr(12'h010, 32'd0); wr(12'h014, 32'd1); wr(12'h000, 32'h1);
        idle();
        for (int k = 0; k < 9; k++) begin
            rd(12'h004);
            check("cmp_tdr0",   {32'd0, last_rd}, 64'(k));
            check("cmp_flag",   {63'd0, last_cmp}, {63'd0, (k == 5)});
            check("cmp_int_en", {63'd0, last_int_en}, 64'h1);
        end

        // Debug halt
        do_reset();
        wr(12'h01C, 32'h1); wr(12'h000, 32'h1); idle();
        repeat (5) idle();
        hlv = 1'b1; idle();
        for (int i = 0; i < 4; i++) begin
            rd(12'h004);
            check("halt_tdr0",   {32'd0, last_rd}, 64'd6);
            check("halt_ack",    {63'd0, last_halt_ack}, 64'h1);
            check("halt_cnt_en", {63'd0, last_cnt_en}, 64'h0);
        end
        rd(12'h01C); check("halt_thcsr", {32'd0, last_rd}, 64'h3);
        hlv = 1'b0;
        rd(12'h004); check("resume_d0", {32'd0, last_rd}, 64'd6);
        rd(12'h004); check("resume_d1", {32'd0, last_rd}, 64'd6);
        check("resume_ack", {63'd0, last_halt_ack}, 64'h0);
        rd(12'h004); check("resume_d2", {32'd0, last_rd}, 64'd7);

        // TCR write rules, stop clearing, unmapped access
        do_reset();
        wr(12'h000, 32'h1); idle(); repeat (3) idle();
        wr(12'h000, 32'h0000_0903);
        rd(12'h000); check("tcr_bad_div", {32'd0, last_rd}, 64'h1);
        wr(12'h000, 32'h0000_0203);
        rd(12'h000); check("tcr_div_locked", {32'd0, last_rd}, 64'h1);
        wr(12'h000, 32'h0); idle();
        rd(12'h004); check("stop_clear", {32'd0, last_rd}, 64'd0);
        wr(12'h018, 32'hFFFF_FFFF);
        rd(12'h018); check("unmapped_rd", {32'd0, last_rd}, 64'd0);

        // Reset beats a concurrent write
        rsv = 1'b1; wr(12'h00C, 32'h1234); rsv = 1'b0;
        rd(12'h00C); check("rst_over_wr", {32'd0, last_rd}, 64'hFFFF_FFFF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [11:0] a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                rsv = 1'b1; idle(); rsv = 1'b0;
            end else if (r < 8) begin
                hlv = ~hlv; idle();
            end else if (r < 28) begin
                a = addr_tab[$urandom_range(0, 7)];
                if ($urandom_range(0, 19) == 0) a = 12'($urandom);
                d = $urandom;
                case (a)
                    12'h000: begin
                        d[11:8] = 4'($urandom_range(0, 10));
                        if (d[11:8] > 4'd3 && d[11:8] <= 4'd8 && $urandom_range(0, 1) == 1) d[11:8] = 4'd1;
                        d[0] = ($urandom_range(0, 9) != 0);
                    end
                    12'h004: if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    12'h00C: d = m_cnt[31:0] + 32'($urandom_range(0, 20));
                    12'h010: d = m_cnt[63:32];
                    default: ;
                endcase
                if ($urandom_range(0, 9) == 0) cyc(1'b1, 1'b1, a, d);
                else wr(a, d);
            end else if (r < 55) begin
                a = addr_tab[$urandom_range(0, 7)];
                if ($urandom_range(0, 19) == 0) a = 12'($urandom);
                rd(a);
            end else begin
                idle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
